// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation,
// so both ends of the link compute identical bit periods.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable
// reset value so idle-high lines do not look active coming out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, one-cycle strobes
// for good bytes and framing errors, and a break state for held-low lines.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    logic             w_rx_s;
    rx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_busy;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // Receive state machine with registered data, strobes and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= 3'd0;
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        r_idx <= 3'd0;
                        if (!w_rx_s) begin
                            r_state <= ST_DATA;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Only a return to idle-high re-arms the receiver.
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= 3'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at a reduced bit period: stimulus pushes the
// expected events, a negedge monitor pops and compares every strobe.
module tb_uart_rx;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned LAT  = 2 + HALF + 9 * CPB;

    typedef struct {
        logic        is_err;
        logic [7:0]  data;
        logic        chk_lat;
        logic        chk_gap;
        int unsigned t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_valid_cyc = 0;
    logic [7:0]  last_good = 8'h00;

    uart_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic is_err, input logic [7:0] d, input logic lat, input logic gap);
        exp_t e;
        e.is_err  = is_err;
        e.data    = d;
        e.chk_lat = lat;
        e.chk_gap = gap;
        e.t0      = cyc;
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop_v, CPB);
    endtask

    task automatic check_reset_outputs();
        check("rst_data",  {24'd0, rx_data}, 32'h00);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr",  {31'd0, rx_frame_err}, 32'd0);
        check("rst_busy",  {31'd0, rx_busy}, 32'd0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (rx_valid || rx_frame_err)) begin
            check("strobe_exclusive", {31'd0, rx_valid & rx_frame_err}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got valid=%0b ferr=%0b data=0x%0h, expected none",
                         rx_valid, rx_frame_err, rx_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_kind", {31'd0, rx_frame_err}, {31'd0, e.is_err});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                if (e.chk_lat) begin
                    checks++;
                    if ((cyc - e.t0) + 2 < LAT || (cyc - e.t0) > LAT + 2) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, expected %0d +/-2", cyc - e.t0, LAT);
                    end
                end
                if (e.chk_gap) check("b2b_gap", cyc - last_valid_cyc, 10 * CPB);
                if (rx_valid) last_valid_cyc = cyc;
            end
        end
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        drive(1'b1, 20);

        // Single frame with latency measurement.
        push(1'b0, 8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1);
        last_good = 8'hA5;
        drive(1'b1, 2 * CPB);

        // Back-to-back frames, zero idle.
        push(1'b0, 8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1);
        push(1'b0, 8'hFF, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1);
        last_good = 8'hFF;
        drive(1'b1, 2 * CPB);
        check("idle_busy", {31'd0, rx_busy}, 32'd0);

        // Short low glitch: busy briefly, no strobe.
        drive(1'b0, 4);
        check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
        drive(1'b1, HALF + 6);
        check("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);

        // Framing error then held-low break, then a good frame.
        push(1'b1, last_good, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 3 * CPB);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        drive(1'b1, 2 * CPB);
        check("break_release", {31'd0, rx_busy}, 32'd0);
        push(1'b0, 8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1);
        last_good = 8'h81;
        drive(1'b1, 2 * CPB);

        // Reset in the middle of data bit 4.
        b = 8'hE7;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(b[i], CPB);
        drive(b[4], HALF);
        rst = 1'b1;
        rx  = 1'b1;
        drive(1'b1, 3);
        check_reset_outputs();
        last_good = 8'h00;
        rst = 1'b0;
        drive(1'b1, CPB);
        push(1'b0, 8'h42, 1'b0, 1'b0);
        send_frame(8'h42, 1'b1);
        drive(1'b1, 2 * CPB);

        // Loopback-style stream: fixed patterns then random bytes.
        for (int i = 0; i < 68; i++) begin
            case (i)
                0:       b = 8'h00;
                1:       b = 8'h55;
                2:       b = 8'hAA;
                3:       b = 8'hFF;
                default: b = 8'($urandom_range(0, 255));
            endcase
            push(1'b0, b, 1'b0, 1'b0);
            send_frame(b, 1'b1);
            drive(1'b1, 1 + $urandom_range(0, 20));
        end

        for (int i = 0; i < 20 * CPB && q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'd0);
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

- Serial receiver for the UART link: 8 data bits, LSB first, no parity, 1 stop bit (8N1).
- Recovers bytes from the asynchronous `rx` line using a 2-flop synchroniser and mid-bit sampling.
- Presents each byte as a one-cycle valid strobe.
- Sits at the top of the UART path, the counterpart to the `tx` block; loopback `tx`→`rx` is the reference system test.

## Interface

Parameters:
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line bit rate.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last correctly framed byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` new in that cycle.
- `rx_frame_err`  out  1  one-cycle pulse, stop bit sampled low.
- `rx_busy`  out  1  high in any state other than IDLE.

## Operation

- Derived constants:
  - `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division; 5208 at defaults.
  - `HALF_BIT = CLKS_PER_BIT/2`; 2604 at defaults.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. The bit index is 3 bits.
- Synchroniser: two flops on `rx`, both reset to 1. All decisions use the second flop (`rx_s`).
- State machine: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - Counter and bit index held at 0.
  - When `rx_s`==0, go to START.
- START:
  - Count to `HALF_BIT-1`, then sample.
  - `rx_s`==0 → DATA, counter cleared, bit index 0.
  - `rx_s`==1 → glitch; return to IDLE with no output pulse.
- DATA:
  - Count to `CLKS_PER_BIT-1`, then sample `rx_s` into the shift register: right shift, sample enters bit 7.
  - Increment bit index and clear the counter.
  - After the sample at index 7, go to STOP.
- STOP:
  - Count to `CLKS_PER_BIT-1`, then sample.
  - `rx_s`==1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - `rx_s`==0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to BREAK.
- BREAK: wait until `rx_s`==1, then go to IDLE. This stops a held-low line (break) from retriggering frames.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- No overrun handling: the consumer must take `rx_data` within one frame time.

## Timing

- Reset values:
  - State IDLE; counters 0; shift register 0.
  - `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0.
  - Synchroniser flops = 1.
- Reset mid-frame aborts immediately. After release, the receiver waits in IDLE for the next falling edge; the partial byte is never reported.
- Latency from the start-bit falling edge at the `rx` pin to `rx_valid` high: 2 + `HALF_BIT` + 9·`CLKS_PER_BIT` cycles. This is 49478 cycles at defaults; the bench allows ±2 cycles.
- Sample point is the bit centre, within ±2 clk.
- Tolerates baud mismatch up to ±2% between transmitter and receiver.
- Back-to-back frames:
  - IDLE is re-entered at mid-stop-bit.
  - A start edge arriving ≥1 cycle later must be caught.
  - Zero inter-frame idle is supported.
- `rx_busy` rises the cycle after `rx_s` falls in IDLE. It falls the cycle IDLE is re-entered; in BREAK it stays high.

## Structure

- Shared package `uart_pkg`:
  - State enum (IDLE, START, DATA, STOP, BREAK).
  - Helper function for `CLKS_PER_BIT` from `CLK_FREQ`/`BAUD`.
  - Shared with `tx` so both ends derive identical bit timing.
- One sub-module: `sync_2ff` (1-bit, reset value parameter, async reset). It is reused for any other asynchronous input.
- Everything else lives in `uart_rx`. Expected size is about 150 lines.

## Test plan

- Send 0xA5 at 9600 baud after reset release → one `rx_valid` pulse with `rx_data`=0xA5, at 49478±2 cycles after the start edge; `rx_frame_err` stays 0.
- Send 0x5A and then 0xFF back-to-back with zero idle → two `rx_valid` pulses, data 0x5A then 0xFF, one frame time apart.
- Drive a 1000-cycle low glitch on an idle line → no `rx_valid`, no `rx_frame_err`; `rx_busy` returns to 0 after the half-bit check.
- Send 0x3C with the stop bit driven low, then hold the line low for 3 bit times and release → one `rx_frame_err` pulse; `rx_data` keeps its previous value; no new frame until after the release; a following 0x81 is received correctly.
- Assert `rst` during data bit 4 of a frame, release, then send 0x42 → outputs at reset values during reset; the aborted frame is never reported; 0x42 is received correctly.
- Loopback with `tx`: send 0x00, 0x55, 0xAA, 0xFF and 64 random bytes → every byte is received equal, with no frame errors.
